mips_test_sequencer: RTL and testbench



---
 rtl/mips_test_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_mips_test_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_test_sequencer.sv
// Run controller for a mips_cpu_bus harness: sequences CPU reset, times the run,
// watches the bus for protocol violations and grades register_v0 at halt.
module mips_test_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned RESET_CYCLES   = 1,
    parameter logic [31:0] EXPECTED_V0    = 32'h0000_0000,
    parameter logic [31:0] V0_MASK        = 32'hFFFF_FFFF,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    output logic             cpu_reset_o,
    input  logic             cpu_active_i,
    input  logic [31:0]      register_v0_i,
    input  logic             bus_read_i,
    input  logic             bus_write_i,
    input  logic             bus_waitrequest_i,
    input  logic [3:0]       bus_byteenable_i,
    output logic             done_o,
    output logic             pass_o,
    output logic [2:0]       fail_code_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [CNT_W-1:0] read_count_o,
    output logic [CNT_W-1:0] write_count_o,
    output logic [31:0]      v0_captured_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_e;

    localparam int unsigned HOLD_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [2:0]  FC_NONE    = 3'd0;
    localparam logic [2:0]  FC_TIMEOUT = 3'd1;
    localparam logic [2:0]  FC_V0      = 3'd2;
    localparam logic [2:0]  FC_BUS     = 3'd3;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   rdcnt_q, rdcnt_d;
    logic [CNT_W-1:0]   wrcnt_q, wrcnt_d;
    logic [31:0]        v0_q, v0_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [2:0]         fc_q, fc_d;
    logic               err_q, err_d;
    logic               tmo_q, tmo_d;
    logic               rd_stall_q, rd_stall_d;
    logic               wr_stall_q, wr_stall_d;
    logic               clr;
    logic               bus_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A strobe that was stalled must still be asserted on the following cycle.
    always_comb begin
        bus_err = (bus_read_i & bus_write_i)
                | ((bus_read_i | bus_write_i) & (bus_byteenable_i == 4'b0000))
                | (rd_stall_q & ~bus_read_i)
                | (wr_stall_q & ~bus_write_i);
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cycle_d    = cycle_q;
        rdcnt_d    = rdcnt_q;
        wrcnt_d    = wrcnt_q;
        v0_d       = v0_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fc_d       = fc_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        rd_stall_d = 1'b0;
        wr_stall_d = 1'b0;
        clr        = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_HOLD;
                    clr     = 1'b1;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    hold_d  = '0;
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_RUN: begin
                cycle_d    = sat_inc(cycle_q);
                rd_stall_d = bus_read_i & bus_waitrequest_i;
                wr_stall_d = bus_write_i & bus_waitrequest_i;
                if (bus_err)
                    err_d = 1'b1;
                if (bus_read_i & ~bus_waitrequest_i)
                    rdcnt_d = sat_inc(rdcnt_q);
                if (bus_write_i & ~bus_waitrequest_i)
                    wrcnt_d = sat_inc(wrcnt_q);
                // A halting CPU takes precedence over a timeout landing on the same cycle.
                if (!cpu_active_i) begin
                    state_d = S_CHECK;
                end else if (64'(cycle_d) >= 64'(TIMEOUT_CYCLES)) begin
                    tmo_d   = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                v0_d = register_v0_i;
                if (err_q)
                    fc_d = FC_BUS;
                else if (tmo_q)
                    fc_d = FC_TIMEOUT;
                else if (((register_v0_i ^ EXPECTED_V0) & V0_MASK) != 32'h0)
                    fc_d = FC_V0;
                else
                    fc_d = FC_NONE;
                pass_d  = (fc_d == FC_NONE);
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clr) begin
            hold_d  = '0;
            cycle_d = '0;
            rdcnt_d = '0;
            wrcnt_d = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            fc_d    = FC_NONE;
            err_d   = 1'b0;
            tmo_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            cycle_q    <= '0;
            rdcnt_q    <= '0;
            wrcnt_q    <= '0;
            v0_q       <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fc_q       <= FC_NONE;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            rd_stall_q <= 1'b0;
            wr_stall_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cycle_q    <= cycle_d;
            rdcnt_q    <= rdcnt_d;
            wrcnt_q    <= wrcnt_d;
            v0_q       <= v0_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fc_q       <= fc_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            rd_stall_q <= rd_stall_d;
            wr_stall_q <= wr_stall_d;
        end
    end

    // CPU runs only while the sequencer is in RUN or grading in CHECK.
    assign cpu_reset_o   = ~((state_q == S_RUN) || (state_q == S_CHECK));
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign fail_code_o   = fc_q;
    assign cycle_count_o = cycle_q;
    assign read_count_o  = rdcnt_q;
    assign write_count_o = wrcnt_q;
    assign v0_captured_o = v0_q;

endmodule

// File: tb/tb_mips_test_sequencer.sv
// Directed bench for mips_test_sequencer: three differently parameterised
// instances share the CPU/bus stimulus, each with its own start pulse.
module tb_mips_test_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, start_c;
    logic        cpu_active;
    logic [31:0] v0;
    logic        rd, wr, wt;
    logic [3:0]  be;

    logic        cpu_reset_a, done_a, pass_a;
    logic [2:0]  fc_a;
    logic [31:0] cyc_a, rdc_a, wrc_a, v0c_a;
    logic        cpu_reset_b, done_b, pass_b;
    logic [2:0]  fc_b;
    logic [31:0] cyc_b, rdc_b, wrc_b, v0c_b;
    logic        cpu_reset_c, done_c, pass_c;
    logic [2:0]  fc_c;
    logic [2:0]  cyc_c, rdc_c, wrc_c;
    logic [31:0] v0c_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_test_sequencer #(.TIMEOUT_CYCLES(100), .RESET_CYCLES(2)) u_a (
        .clk_i(clk), .reset_i(rst_n), .start_i(start_a), .cpu_reset_o(cpu_reset_a),
        .cpu_active_i(cpu_active), .register_v0_i(v0), .bus_read_i(rd), .bus_write_i(wr),
        .bus_waitrequest_i(wt), .bus_byteenable_i(be), .done_o(done_a), .pass_o(pass_a),
        .fail_code_o(fc_a), .cycle_count_o(cyc_a), .read_count_o(rdc_a),
        .write_count_o(wrc_a), .v0_captured_o(v0c_a));

    mips_test_sequencer #(.TIMEOUT_CYCLES(20), .RESET_CYCLES(1),
                          .EXPECTED_V0(32'h0000_00FF), .V0_MASK(32'h0000_00FF)) u_b (
        .clk_i(clk), .reset_i(rst_n), .start_i(start_b), .cpu_reset_o(cpu_reset_b),
        .cpu_active_i(cpu_active), .register_v0_i(v0), .bus_read_i(rd), .bus_write_i(wr),
        .bus_waitrequest_i(wt), .bus_byteenable_i(be), .done_o(done_b), .pass_o(pass_b),
        .fail_code_o(fc_b), .cycle_count_o(cyc_b), .read_count_o(rdc_b),
        .write_count_o(wrc_b), .v0_captured_o(v0c_b));

    mips_test_sequencer #(.TIMEOUT_CYCLES(1000), .RESET_CYCLES(1), .CNT_W(3)) u_c (
        .clk_i(clk), .reset_i(rst_n), .start_i(start_c), .cpu_reset_o(cpu_reset_c),
        .cpu_active_i(cpu_active), .register_v0_i(v0), .bus_read_i(rd), .bus_write_i(wr),
        .bus_waitrequest_i(wt), .bus_byteenable_i(be), .done_o(done_c), .pass_o(pass_c),
        .fail_code_o(fc_c), .cycle_count_o(cyc_c), .read_count_o(rdc_c),
        .write_count_o(wrc_c), .v0_captured_o(v0c_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start on u_a and walk through its two HOLD cycles into RUN.
    task automatic launch_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick(); tick();
    endtask

    // Drop cpu_active, let CHECK and DONE follow, then park the CPU signals again.
    task automatic halt();
        cpu_active = 1'b0; tick(); tick();
        cpu_active = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        cpu_active = 1'b1; v0 = 32'h0; rd = 1'b0; wr = 1'b0; wt = 1'b0; be = 4'hF;
        tick(); tick();
        chk("rst_cpu_reset", cpu_reset_a, 1);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_fc", fc_a, 0);
        chk("rst_cyc", cyc_a, 0);
        chk("rst_v0c", v0c_a, 0);
        rst_n = 1'b1;
        tick();

        // Normal halt after 50 RUN cycles, RESET_CYCLES=2
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("t1_hold1_cpu_reset", cpu_reset_a, 1);
        tick();
        chk("t1_hold2_cpu_reset", cpu_reset_a, 1);
        tick();
        chk("t1_run_cpu_reset", cpu_reset_a, 0);
        repeat (49) tick();
        chk("t1_cyc49", cyc_a, 49);
        cpu_active = 1'b0; tick();
        chk("t1_check_done", done_a, 0);
        chk("t1_check_cpu_reset", cpu_reset_a, 0);
        tick();
        cpu_active = 1'b1;
        chk("t1_done", done_a, 1);
        chk("t1_pass", pass_a, 1);
        chk("t1_fc", fc_a, 0);
        chk("t1_cyc", cyc_a, 50);
        chk("t1_done_cpu_reset", cpu_reset_a, 1);
        repeat (3) tick();
        chk("t1_done_held", done_a, 1);
        chk("t1_cyc_held", cyc_a, 50);

        // Masked v0 compare
        v0 = 32'hABCD_00FF;
        start_b = 1'b1; tick(); start_b = 1'b0;
        tick();
        chk("t2_run_cpu_reset", cpu_reset_b, 0);
        halt();
        chk("t2a_done", done_b, 1);
        chk("t2a_pass", pass_b, 1);
        chk("t2a_fc", fc_b, 0);
        chk("t2a_v0c", v0c_b, 32'hABCD_00FF);
        chk("t2a_cyc", cyc_b, 1);
        v0 = 32'h0000_00FE;
        start_b = 1'b1; tick(); start_b = 1'b0;
        chk("t2b_cleared_done", done_b, 0);
        chk("t2b_cleared_cyc", cyc_b, 0);
        tick();
        halt();
        chk("t2b_fc", fc_b, 2);
        chk("t2b_pass", pass_b, 0);
        chk("t2b_v0c", v0c_b, 32'h0000_00FE);

        // Timeout at 20 RUN cycles; v0 correct but not compared
        v0 = 32'h0000_00FF;
        start_b = 1'b1; tick(); start_b = 1'b0;
        tick();
        repeat (19) tick();
        chk("t3_cyc19_done", done_b, 0);
        chk("t3_cyc19", cyc_b, 19);
        tick();
        chk("t3_check_cyc", cyc_b, 20);
        tick();
        chk("t3_done", done_b, 1);
        chk("t3_fc", fc_b, 1);
        chk("t3_cyc", cyc_b, 20);
        chk("t3_v0c", v0c_b, 32'h0000_00FF);
        // Halt on the very cycle the timeout is reached: halt wins
        start_b = 1'b1; tick(); start_b = 1'b0;
        tick();
        repeat (19) tick();
        halt();
        chk("t3b_fc", fc_b, 0);
        chk("t3b_pass", pass_b, 1);
        chk("t3b_cyc", cyc_b, 20);

        // Bus protocol: read and write together
        v0 = 32'h0;
        launch_a();
        rd = 1'b1; wr = 1'b1; tick();
        rd = 1'b0; wr = 1'b0;
        repeat (3) tick();
        halt();
        chk("t4a_fc", fc_a, 3);
        chk("t4a_pass", pass_a, 0);
        // Read dropped during a stall
        launch_a();
        rd = 1'b1; wt = 1'b1; tick();
        rd = 1'b0; wt = 1'b0; tick();
        halt();
        chk("t4b_fc", fc_a, 3);
        chk("t4b_rdc", rdc_a, 0);
        // Strobe with no byte enables
        launch_a();
        wr = 1'b1; be = 4'h0; tick();
        wr = 1'b0; be = 4'hF;
        halt();
        chk("t4c_fc", fc_a, 3);
        // Three reads with two stall cycles each plus one write; illegal bus outside RUN
        start_a = 1'b1; tick(); start_a = 1'b0;
        rd = 1'b1; wr = 1'b1; be = 4'h0;
        tick(); tick();
        rd = 1'b0; wr = 1'b0; be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            rd = 1'b1; wt = 1'b1; tick(); tick();
            wt = 1'b0; tick();
            rd = 1'b0; tick();
        end
        wr = 1'b1; be = 4'h3; tick();
        wr = 1'b0; be = 4'hF;
        halt();
        chk("t4d_rdc", rdc_a, 3);
        chk("t4d_wrc", wrc_a, 1);
        chk("t4d_fc", fc_a, 0);
        chk("t4d_pass", pass_a, 1);
        chk("t4d_cyc", cyc_a, 14);

        // Start mid-run ignored, then reset aborts
        launch_a();
        repeat (5) tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("t5_start_ignored_cpu_reset", cpu_reset_a, 0);
        chk("t5_start_ignored_cyc", cyc_a, 6);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("t5_abort_cpu_reset", cpu_reset_a, 1);
        chk("t5_abort_done", done_a, 0);
        chk("t5_abort_cyc", cyc_a, 0);
        chk("t5_abort_rdc", rdc_a, 0);
        chk("t5_abort_fc", fc_a, 0);
        tick();
        chk("t5_idle_cpu_reset", cpu_reset_a, 1);
        // Start from DONE clears the previous result
        launch_a();
        repeat (3) tick();
        halt();
        chk("t5_run_done", done_a, 1);
        chk("t5_run_cyc", cyc_a, 4);
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("t5_restart_done", done_a, 0);
        chk("t5_restart_cyc", cyc_a, 0);
        chk("t5_restart_cpu_reset", cpu_reset_a, 1);
        tick(); tick();
        chk("t5_restart_run", cpu_reset_a, 0);

        // Counter saturation with CNT_W=3
        start_c = 1'b1; tick(); start_c = 1'b0;
        tick();
        rd = 1'b1;
        repeat (10) tick();
        rd = 1'b0;
        chk("t6_cyc_sat", cyc_c, 7);
        chk("t6_rdc_sat", rdc_c, 7);
        halt();
        chk("t6_done", done_c, 1);
        chk("t6_cyc_final", cyc_c, 7);
        chk("t6_pass", pass_c, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
